// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and enums for the npc multi-cycle core.
// Holds opcodes, the FSM state enum, the ALU-op enum and regfile size.
package npc_pkg;

    localparam int NREG = 32;

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

endpackage

// File: rtl/npc_regfile.sv
// npc_regfile: NREG x XLEN integer registers, x0 hardwired to zero.
// Ports: clk, rst (async, active-high), ra1/rd1, ra2/rd2 (async read),
// we/wa/wd (write on rising clk).
module npc_regfile
    import npc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV core (FETCH/EXEC/WB/HALT), OP-IMM, LUI,
// AUIPC, JAL, JALR. Ports: clk, rst (async, active-high); imem_req,
// imem_addr, imem_ready, imem_rdata (fetch); wb_valid, wb_rd, wb_data
// (retire); pc_out; illegal (pulse); fault (sticky fetch timeout).
// Define NPC_EBREAK_EN to make ebreak halt; otherwise it is illegal.
module npc_mc_core
    import npc_pkg::*;
#(
    parameter int          XLEN          = 64,
    parameter logic [63:0] RESET_PC      = 64'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal,
    output logic            fault
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [XLEN-1:0] PC0 = RESET_PC[XLEN-1:0];
    localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);

    state_e          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc_q;
    logic [31:0]     ir;
    logic [CW-1:0]   wcnt;
    logic            halt_q;

    logic [6:0]      opc;
    logic [XLEN-1:0] rs1v, rs2v;
    logic [XLEN-1:0] iimm, uimm, jimm;
    logic [XLEN-1:0] pc4, jsum;
    logic [XLEN-1:0] a, b, alu, nxt;
    logic [5:0]      sh;
    alu_op_e         op;
    logic            ill, brk;
    logic            unused_rs2;

    assign opc  = ir[6:0];
    assign iimm = XLEN'($signed(ir[31:20]));
    assign uimm = XLEN'($signed({ir[31:12], 12'b0}));
    assign jimm = XLEN'($signed({ir[31], ir[19:12],
                                 ir[20], ir[30:21], 1'b0}));
    assign pc4  = pc + XLEN'(4);
    assign jsum = rs1v + iimm;
    assign sh   = (XLEN == 64) ? ir[25:20] : {1'b0, ir[24:20]};

`ifdef NPC_EBREAK_EN
    assign brk = (ir == EBREAK);
`else
    assign brk = 1'b0;
`endif

    npc_regfile #(.XLEN(XLEN)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (ir[19:15]),
        .rd1 (rs1v),
        .ra2 (ir[24:20]),
        .rd2 (rs2v),
        .we  (state == S_WB && wb_valid),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    assign unused_rs2 = ^rs2v;

    always_comb begin
        op  = ALU_ADD;
        a   = rs1v;
        b   = iimm;
        ill = 1'b0;
        nxt = pc4;
        unique case (1'b1)
            opc == OP_IMM: begin
                unique case (ir[14:12])
                    3'b000: op = ALU_ADD;
                    3'b001: op = ALU_SLL;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b101: op = ir[30] ? ALU_SRA : ALU_SRL;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                endcase
            end
            opc == OP_LUI: begin
                a = '0;
                b = uimm;
            end
            opc == OP_AUIPC: begin
                a = pc;
                b = uimm;
            end
            opc == OP_JAL: begin
                a   = pc;
                b   = XLEN'(4);
                nxt = pc + jimm;
            end
            opc == OP_JALR: begin
                a   = pc;
                b   = XLEN'(4);
                nxt = {jsum[XLEN-1:1], 1'b0};
            end
            default: ill = ~brk;
        endcase
    end

    always_comb begin
        unique case (op)
            ALU_SLT:  alu = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: alu = XLEN'(a < b);
            ALU_XOR:  alu = a ^ b;
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            ALU_SLL:  alu = a << sh;
            ALU_SRL:  alu = a >> sh;
            ALU_SRA:  alu = $signed(a) >>> sh;
            default:  alu = a + b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= PC0;
            npc_q    <= '0;
            ir       <= '0;
            wcnt     <= '0;
            halt_q   <= 1'b0;
            fault    <= 1'b0;
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        wcnt  <= '0;
                        state <= S_EXEC;
                    end else if (wcnt == LAST) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                S_EXEC: begin
                    wb_valid <= ~(ill | brk);
                    illegal  <= ill;
                    wb_rd    <= ir[11:7];
                    wb_data  <= alu;
                    // ebreak parks the PC on itself
                    npc_q    <= brk ? pc : nxt;
                    halt_q   <= brk;
                    state    <= S_WB;
                end
                S_WB: begin
                    pc    <= npc_q;
                    state <= halt_q ? S_HALT : S_FETCH;
                end
                S_HALT: state <= S_HALT;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;

endmodule

// File: tb/tb_npc_mc_core.sv
// tb_npc_mc_core: scoreboard bench for npc_mc_core (XLEN=64).
// Expected retires are queued at fetch and popped on wb_valid/illegal.
module tb_npc_mc_core;

    localparam int          XLEN = 64;
    localparam int          TMO  = 16;
    localparam logic [63:0] R    = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] pc_out;
    logic            illegal;
    logic            fault;

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nerr = 0;
    logic [63:0] mpc;

    npc_mc_core #(
        .XLEN          (XLEN),
        .RESET_PC      (R),
        .FETCH_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .pc_out     (pc_out),
        .illegal    (illegal),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", 64'(imem_req), 64'd1);
        chk("fetch_addr", imem_addr, mpc);
    endtask

    task automatic drive(input logic [31:0] insn, input int stall);
        wait_req();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("req_hold", 64'(imem_req), 64'd1);
            chk("addr_hold", imem_addr, mpc);
        end
        imem_ready = 1'b1;
        imem_rdata = insn;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic issue(input logic [31:0] insn,
                         input int stall,
                         input logic ill,
                         input logic [4:0] rd,
                         input logic [63:0] data,
                         input logic [63:0] npc);
        exp_t e;
        e.ill  = ill;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
        drive(insn, stall);
        mpc = npc;
    endtask

    always @(negedge clk) begin
        if (!rst && (wb_valid || illegal)) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 64'({wb_valid, illegal}), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("kind", 64'({wb_valid, illegal}),
                    mon_e.ill ? 64'd1 : 64'd2);
                if (!mon_e.ill) begin
                    chk("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
                    chk("wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        mpc        = R;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'd1);
        chk("rst_pc", pc_out, R);
        chk("rst_addr", imem_addr, R);
        chk("rst_wbv", 64'(wb_valid), 64'd0);
        chk("rst_ill", 64'(illegal), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        rst = 1'b0;

        issue(32'h0050_0093, 0, 1'b0, 5'd1, 64'd5, R + 4);
        issue(32'hFFF0_8113, 10, 1'b0, 5'd2, 64'd4, R + 8);

        // reset while the next instruction is in EXEC
        drive(32'h0070_0193, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc_out, R);
        chk("mid_rst_req", 64'(imem_req), 64'd1);
        chk("mid_rst_wbv", 64'(wb_valid), 64'd0);
        chk("mid_rst_data", wb_data, 64'd0);
        chk("mid_rst_fault", 64'(fault), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = R;

        issue(32'hFFF0_8113, 0, 1'b0, 5'd2, '1, R + 4);
        issue(32'h43F1_5193, 0, 1'b0, 5'd3, '1, R + 8);
        issue(32'h03C1_5213, 1, 1'b0, 5'd4, 64'hF, R + 12);
        issue(32'h0010_0293, 0, 1'b0, 5'd5, 64'd1, R + 16);
        issue(32'h01F2_9293, 0, 1'b0, 5'd5,
              64'h8000_0000, R + 20);
        issue(32'h0032_E293, 0, 1'b0, 5'd5,
              64'h8000_0003, R + 24);
        issue(32'h0042_80E7, 2, 1'b0, 5'd1,
              64'h8000_001C, 64'h8000_0006);
        issue(32'h0000_00B3, 0, 1'b1, 5'd0, '0, 64'h8000_000A);
        issue(32'h0000_8313, 0, 1'b0, 5'd6,
              64'h8000_001C, 64'h8000_000E);
        issue(32'h8000_03B7, 0, 1'b0, 5'd7,
              64'hFFFF_FFFF_8000_0000, 64'h8000_0012);
        issue(32'h0000_1417, 0, 1'b0, 5'd8,
              64'h8000_1012, 64'h8000_0016);
        issue(32'h0001_2493, 0, 1'b0, 5'd9, 64'd1, 64'h8000_001A);
        issue(32'hFFF1_3513, 0, 1'b0, 5'd10, 64'd0, 64'h8000_001E);
        issue(32'hFFF2_C593, 0, 1'b0, 5'd11,
              64'hFFFF_FFFF_7FFF_FFFC, 64'h8000_0022);
        issue(32'h0062_7613, 0, 1'b0, 5'd12, 64'd6, 64'h8000_0026);
        issue(32'h0090_0013, 0, 1'b0, 5'd0, 64'd9, 64'h8000_002A);
        issue(32'h0010_0693, 0, 1'b0, 5'd13, 64'd1, 64'h8000_002E);
        issue(32'hFF1F_F76F, 0, 1'b0, 5'd14,
              64'h8000_0032, 64'h8000_001E);
        issue(32'h0010_3793, 0, 1'b0, 5'd15, 64'd1, 64'h8000_0022);
        issue(32'hFFE0_0813, TMO - 1, 1'b0, 5'd16,
              64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0026);

`ifdef NPC_EBREAK_EN
        drive(32'h0010_0073, 0);
        for (int i = 0; i < 6; i++) begin
            imem_ready = 1'b1;
            @(negedge clk);
            chk("halt_req", 64'(imem_req), 64'd0);
        end
        imem_ready = 1'b0;
        chk("halt_pc", pc_out, mpc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mpc = R;
`else
        issue(32'h0010_0073, 0, 1'b1, 5'd0, '0, mpc + 4);
`endif

        // fetch timeout: fault exactly after TMO idle cycles
        wait_req();
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            chk("tmo_early", 64'(fault), 64'd0);
        end
        @(negedge clk);
        chk("tmo_fault", 64'(fault), 64'd1);
        chk("tmo_req", 64'(imem_req), 64'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        repeat (3) begin
            @(negedge clk);
            chk("halt_ignore", 64'(imem_req), 64'd0);
        end
        imem_ready = 1'b0;
        chk("fault_sticky", 64'(fault), 64'd1);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
